sampled_pfd: RTL and testbench

Clock-sampled, parametrised phase-frequency detector for the digital PLL loop. It oversamples the reference clock f_ref and the divided VCO clock f_div with the system clock clk. For each edge pair it measures the signed lead/lag in clk cycles and reports it as a multi-bit error word for the loop filter. It also provides legacy up/dn/dir outputs, frequency-mode cycle-slip detection and a lock indicator.

---
 rtl/pfd_pkg.sv | 18 +
 rtl/sampled_pfd_edge_sync.sv | 31 +++
 rtl/sampled_pfd.sv | 168 ++++++++++++++++
 tb/tb_sampled_pfd.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pfd_pkg.sv
// Shared types and constants for the clock-sampled phase-frequency detector.
package pfd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REF_LEAD = 2'd1,
        ST_DIV_LEAD = 2'd2
    } pfd_state_e;

    // dir encoding: which way the loop should push the VCO
    localparam logic DIR_SPEED_UP  = 1'b1;
    localparam logic DIR_SLOW_DOWN = 1'b0;

    function automatic int err_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sampled_pfd_edge_sync.sv
// Multi-flop synchroniser for an asynchronous clock input plus one-cycle rising-edge detect.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/sampled_pfd.sv
// Sampled PFD: measures signed ref/div edge offset in clk cycles, with slip detect and lock flag.
module sampled_pfd
    import pfd_pkg::*;
#(
    parameter int ERR_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 2,
    parameter int LOCK_CNT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_ref,
    input  logic             f_div,
    input  logic             enable,
    output logic [ERR_W-1:0] err,
    output logic             err_valid,
    output logic             up,
    output logic             dn,
    output logic             dir,
    output logic             slip,
    output logic             locked
);

    localparam int               ERR_MAX = err_max(ERR_W);
    localparam logic [ERR_W-2:0] CNT_MAX = ERR_MAX[ERR_W-2:0];
    localparam logic [ERR_W-2:0] CNT_ONE = {{(ERR_W-2){1'b0}}, 1'b1};
    localparam int               LK_W    = $clog2(LOCK_CNT + 1);
    localparam logic [LK_W-1:0]  LK_MAX  = LOCK_CNT[LK_W-1:0];

    logic ref_rise, div_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ref (
        .clk(clk), .rst(rst), .din(f_ref), .rise(ref_rise)
    );
    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_div (
        .clk(clk), .rst(rst), .din(f_div), .rise(div_rise)
    );

    pfd_state_e       state_q, state_d;
    logic [ERR_W-2:0] cnt_q, cnt_d, cnt_inc;
    logic [ERR_W-1:0] err_q, err_d, err_pos, err_mag;
    logic             err_valid_q, err_valid_d;
    logic             slip_q, slip_d;
    logic             up_q, up_d, dn_q, dn_d;
    logic             dir_q, dir_d;
    logic [LK_W-1:0]  lk_q, lk_d;
    logic             locked_q, locked_d;

    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        err_pos = {1'b0, cnt_q};
        err_mag = err_q[ERR_W-1] ? -err_q : err_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_valid_d = 1'b0;
        slip_d      = 1'b0;
        dir_d       = dir_q;
        lk_d        = lk_q;
        locked_d    = locked_q;

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ref_rise && div_rise) begin
                        err_d       = '0;
                        err_valid_d = 1'b1;
                    end else if (ref_rise) begin
                        state_d = ST_REF_LEAD;
                        cnt_d   = CNT_ONE;
                    end else if (div_rise) begin
                        state_d = ST_DIV_LEAD;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_REF_LEAD: begin
                    if (div_rise) begin
                        err_d       = err_pos;
                        err_valid_d = 1'b1;
                        // a coincident ref edge immediately opens the next measurement
                        if (ref_rise) cnt_d = CNT_ONE;
                        else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else if (ref_rise) begin
                        slip_d = 1'b1;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    if (ref_rise) begin
                        err_d       = -err_pos;
                        err_valid_d = 1'b1;
                        if (div_rise) cnt_d = CNT_ONE;
                        else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else if (div_rise) begin
                        slip_d = 1'b1;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            endcase
        end

        if (err_valid_d && err_d != '0)
            dir_d = err_d[ERR_W-1] ? DIR_SLOW_DOWN : DIR_SPEED_UP;
        if (slip_d)
            dir_d = (state_q == ST_REF_LEAD) ? DIR_SPEED_UP : DIR_SLOW_DOWN;

        up_d = (state_d == ST_REF_LEAD);
        dn_d = (state_d == ST_DIV_LEAD);

        // lock tracks the registered measurement, so locked trails the qualifying pulse by one clk
        if (!enable || slip_q || (err_valid_q && err_mag > ERR_W'(LOCK_TOL))) begin
            lk_d     = '0;
            locked_d = 1'b0;
        end else if (err_valid_q) begin
            if (lk_q < LK_MAX) lk_d = lk_q + 1'b1;
            if (lk_d == LK_MAX) locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            slip_q      <= 1'b0;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            dir_q       <= 1'b0;
            lk_q        <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            slip_q      <= slip_d;
            up_q        <= up_d;
            dn_q        <= dn_d;
            dir_q       <= dir_d;
            lk_q        <= lk_d;
            locked_q    <= locked_d;
        end
    end

    assign err       = err_q;
    assign err_valid = err_valid_q;
    assign slip      = slip_q;
    assign up        = up_q;
    assign dn        = dn_q;
    assign dir       = dir_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_sampled_pfd.sv
// Directed bench for sampled_pfd: an 8-bit and a 4-bit error instance share stimulus; a scoreboard checks err.
module tb_sampled_pfd;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic f_ref = 1'b0;
    logic f_div = 1'b0;
    logic enable = 1'b1;

    logic [7:0] err8;
    logic [3:0] err4;
    logic v8, up8, dn8, dir8, slip8, lk8;
    logic v4, up4, dn4, dir4, slip4, lk4;

    always #5 clk = ~clk;

    sampled_pfd #(.ERR_W(8), .SYNC_STAGES(2), .LOCK_TOL(1), .LOCK_CNT(4)) dut8 (
        .clk(clk), .rst(rst), .f_ref(f_ref), .f_div(f_div), .enable(enable),
        .err(err8), .err_valid(v8), .up(up8), .dn(dn8), .dir(dir8),
        .slip(slip8), .locked(lk8)
    );

    sampled_pfd #(.ERR_W(4), .SYNC_STAGES(2), .LOCK_TOL(1), .LOCK_CNT(4)) dut4 (
        .clk(clk), .rst(rst), .f_ref(f_ref), .f_div(f_div), .enable(enable),
        .err(err4), .err_valid(v4), .up(up4), .dn(dn4), .dir(dir4),
        .slip(slip4), .locked(lk4)
    );

    typedef struct {
        int e8;
        int e4;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    int   up_cnt, dn_cnt, valid_cnt, slip_cnt, both_cnt;
    logic dir_at_slip, lk_at_valid, lk_after_valid, prev_valid;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (v8 || v4) begin
            exp_t e;
            chk("valid_agree", int'(v4), int'(v8));
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("err8", int'($signed(err8)), e.e8);
                chk("err4", int'($signed(err4)), e.e4);
            end
        end
    end

    always @(negedge clk) begin
        up_cnt    += int'(up4);
        dn_cnt    += int'(dn4);
        valid_cnt += int'(v4);
        slip_cnt  += int'(slip4);
        both_cnt  += int'((up4 && dn4) || (up8 && dn8));
        if (slip4) dir_at_slip = dir4;
        if (prev_valid) lk_after_valid = lk4;
        if (v4) lk_at_valid = lk4;
        prev_valid = v4;
    end

    task automatic clr();
        up_cnt = 0; dn_cnt = 0; valid_cnt = 0; slip_cnt = 0;
    endtask

    // one-cycle pulses at loop indices r0/r1 (ref) and d (div); -1 = none
    task automatic drive(input int r0, input int r1, input int d, input int len);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            f_ref = (i == r0) || (i == r1);
            f_div = (i == d);
        end
        @(negedge clk);
        f_ref = 1'b0;
        f_div = 1'b0;
    endtask

    task automatic push(input int e8, input int e4);
        exp_t e;
        e.e8 = e8;
        e.e4 = e4;
        exp_q.push_back(e);
    endtask

    initial begin
        both_cnt = 0; prev_valid = 0; dir_at_slip = 0; lk_at_valid = 0; lk_after_valid = 0;
        clr();
        repeat (3) @(negedge clk);
        chk("rst_err8", int'(err8), 0);
        chk("rst_valid", int'(v8 | v4), 0);
        chk("rst_updn", int'(up8 | dn8 | up4 | dn4), 0);
        chk("rst_dir", int'(dir8 | dir4), 0);
        chk("rst_slip_lock", int'(slip8 | lk8 | slip4 | lk4), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // simultaneous edges x4
        clr();
        for (int k = 0; k < 4; k++) begin
            push(0, 0);
            drive(0, -1, 0, 8);
        end
        chk("simul_valids", valid_cnt, 4);
        chk("simul_up", up_cnt, 0);
        chk("simul_dn", dn_cnt, 0);
        chk("simul_dir", int'(dir4), 0);

        // ref leads by 5
        clr();
        push(5, 5);
        drive(0, -1, 5, 14);
        chk("ref5_up_cycles", up_cnt, 5);
        chk("ref5_valids", valid_cnt, 1);
        chk("ref5_dir", int'(dir8), 1);
        chk("ref5_unlock", int'(lk4), 0);

        // div leads by 3
        clr();
        push(-3, -3);
        drive(3, -1, 0, 12);
        chk("div3_dn_cycles", dn_cnt, 3);
        chk("div3_up", up_cnt, 0);
        chk("div3_dir", int'(dir8), 0);

        // cycle slip then close 4 after the second ref edge
        clr();
        dir_at_slip = 0;
        push(4, 4);
        drive(0, 10, 14, 22);
        chk("slip_pulses", slip_cnt, 1);
        chk("slip_dir", int'(dir_at_slip), 1);
        chk("slip_valids", valid_cnt, 1);
        chk("slip_slip8", int'(slip8), 0);

        // saturation: 20 fits 8 bits, clamps to 7 in 4 bits
        clr();
        push(20, 7);
        drive(0, -1, 20, 28);
        chk("sat_up_cycles", up_cnt, 20);
        chk("sat_dir", int'(dir4), 1);

        // disable: edges ignored, err/dir held, no stale edge on re-enable
        clr();
        enable = 1'b0;
        drive(0, -1, -1, 8);
        chk("dis_up", up_cnt, 0);
        chk("dis_valid", valid_cnt, 0);
        chk("dis_err_hold", int'($signed(err8)), 20);
        chk("dis_dir_hold", int'(dir8), 1);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        chk("reen_no_stale", up_cnt + dn_cnt + valid_cnt, 0);

        // lock: offsets 1,0,1,0 then 3
        push(1, 1);  drive(0, -1, 1, 10);
        push(0, 0);  drive(0, -1, 0, 10);
        push(1, 1);  drive(0, -1, 1, 10);
        chk("lock_after3", int'(lk4), 0);
        push(0, 0);  drive(0, -1, 0, 10);
        chk("lock_at_4th", int'(lk_at_valid), 0);
        chk("lock_1clk_after", int'(lk_after_valid), 1);
        chk("lock8", int'(lk8), 1);
        push(3, 3);  drive(0, -1, 3, 12);
        chk("unlock_off3", int'(lk4), 0);

        // reset during an open ref-lead measurement
        clr();
        drive(0, -1, -1, 6);
        chk("open_up", int'(up4), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_err", int'(err8), 0);
        chk("mid_rst_outs", int'(up4 | dn4 | dir4 | slip4 | lk4 | v4 | up8 | dir8), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_rst_no_valid", valid_cnt, 0);
        chk("post_rst_up", int'(up4 | up8), 0);

        chk("never_up_dn", both_cnt, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
